// File: rtl/rv_imem_ctrl.sv
// Instruction-memory controller: arbitrates a fetch port against a byte-stream image loader.
// Optional macro IMEM_BOUNDS_CHK_EN adds fetch_err and out-of-range fetch/write handling.
module rv_imem_ctrl #(
  parameter int IMEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
`ifdef IMEM_BOUNDS_CHK_EN
  output logic        fetch_err,
`endif
  input  logic        load_start,
  input  logic [15:0] load_base,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  input  logic        load_end,
  output logic        load_done,
  output logic [15:0] load_words,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {RUN, LOAD, WRITE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] wptr_q, wptr_d;
  logic [15:0] words_q, words_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        end_q, end_d;
  logic        rvalid_q;

  logic        gnt_c, wr_en_c, ready_c, done_c;
  logic [15:0] addr_c;
  logic        wr_oob;
  logic        fetch_oob;

`ifdef IMEM_BOUNDS_CHK_EN
  localparam logic [31:0] LIMIT = 32'(IMEM_SIZE * 1024);
  logic oob_q;
  assign fetch_oob = ({16'h0, fetch_addr} >= LIMIT);
  assign wr_oob    = ({16'h0, wptr_q} >= LIMIT);
`else
  assign fetch_oob = 1'b0;
  assign wr_oob    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    words_d = words_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    end_d   = end_q;
    gnt_c   = 1'b0;
    wr_en_c = 1'b0;
    ready_c = 1'b0;
    done_c  = 1'b0;
    addr_c  = 16'h0;
    case (state_q)
      RUN: begin
        gnt_c  = fetch_req;
        addr_c = fetch_addr;
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = load_base;
          cnt_d   = 2'd0;
          words_d = 16'h0;
          word_d  = 32'h0;
          end_d   = 1'b0;
        end
      end
      LOAD: begin
        ready_c = 1'b1;
        if (load_valid) begin
          word_d = word_q | (32'(load_byte) << {cnt_q, 3'b000});
          cnt_d  = cnt_q + 2'd1;
        end
        // A byte arriving with load_end is folded in before the end is handled.
        if (load_valid && cnt_q == 2'd3) begin
          state_d = WRITE;
          end_d   = load_end;
        end else if (load_end) begin
          if (load_valid || cnt_q != 2'd0) begin
            state_d = WRITE;
            end_d   = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      WRITE: begin
        wr_en_c = !wr_oob;
        addr_c  = wptr_q;
        wptr_d  = wptr_q + 16'd1;
        words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
        cnt_d   = 2'd0;
        word_d  = 32'h0;
        end_d   = 1'b0;
        state_d = end_q ? DRAIN : LOAD;
      end
      DRAIN: begin
        done_c  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wptr_q   <= 16'h0;
      words_q  <= 16'h0;
      cnt_q    <= 2'd0;
      word_q   <= 32'h0;
      end_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      words_q  <= words_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      end_q    <= end_d;
      rvalid_q <= gnt_c;
    end
  end

`ifdef IMEM_BOUNDS_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) oob_q <= 1'b0;
    else        oob_q <= gnt_c & fetch_oob;
  end
  assign fetch_err   = rst_n & rvalid_q & oob_q;
  assign fetch_rdata = (rst_n && rvalid_q) ? (oob_q ? 32'h00000013 : mem_rdata) : 32'h0;
`else
  assign fetch_rdata = (rst_n && rvalid_q) ? mem_rdata : 32'h0;
`endif

  // Outputs are held at zero while reset is asserted, even before the first edge.
  assign fetch_gnt    = rst_n & gnt_c;
  assign fetch_rvalid = rst_n & rvalid_q;
  assign load_ready   = rst_n & ready_c;
  assign load_done    = rst_n & done_c;
  assign load_words   = rst_n ? words_q : 16'h0;
  assign mem_wr_en    = rst_n & wr_en_c;
  assign mem_addr     = rst_n ? addr_c : 16'h0;
  assign mem_wdata    = (rst_n && wr_en_c) ? word_q : 32'h0;

endmodule

// File: tb/tb_rv_imem_ctrl.sv
// Directed bench for rv_imem_ctrl: fetch path, image loading, reset mid-load, optional bounds check.
module tb_rv_imem_ctrl;

`ifdef IMEM_BOUNDS_CHK_EN
  localparam int IMSZ = 1;
`else
  localparam int IMSZ = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
`ifdef IMEM_BOUNDS_CHK_EN
  logic        fetch_err;
`endif
  logic        load_start, load_valid, load_end;
  logic [15:0] load_base;
  logic [7:0]  load_byte;
  logic        load_ready, load_done;
  logic [15:0] load_words;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int wr_cnt   = 0;
  int done_cnt = 0;
  int bad_gnt  = 0;

  rv_imem_ctrl #(.IMEM_SIZE(IMSZ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
`ifdef IMEM_BOUNDS_CHK_EN
    .fetch_err    (fetch_err),
`endif
    .load_start   (load_start),
    .load_base    (load_base),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_ready   (load_ready),
    .load_end     (load_end),
    .load_done    (load_done),
    .load_words   (load_words),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: registered read returning an address-derived pattern.
  always @(posedge clk) mem_rdata <= 32'hA5000000 ^ {16'h0, mem_addr};

  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] <= mem_addr;
        wr_data[wr_cnt] <= mem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
      $display("WR addr=%h data=%h", mem_addr, mem_wdata);
    end
    if (load_done) done_cnt <= done_cnt + 1;
    if (fetch_gnt && (load_ready || mem_wr_en || load_done)) bad_gnt <= bad_gnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one loader beat and hold it until an edge where load_ready is high.
  task automatic send(input logic v, input logic [7:0] b, input logic e);
    bit ok;
    ok = 1'b0;
    load_valid = v;
    load_byte  = b;
    load_end   = e;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = load_ready;
      tick();
    end
    load_valid = 1'b0;
    load_end   = 1'b0;
    check("ready_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = load_done;
      if (!seen) tick();
    end
    check("done_seen", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic start_load(input logic [15:0] base);
    load_start = 1'b1;
    load_base  = base;
    tick();
    load_start = 1'b0;
    load_base  = 16'h0;
  endtask

  int wb, db;

  initial begin
    rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0004;
    load_start = 1'b0; load_base = 16'h0; load_valid = 1'b0; load_byte = 8'h0; load_end = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_gnt",    32'(fetch_gnt),    32'd0);
    check("rst_rvalid", 32'(fetch_rvalid), 32'd0);
    check("rst_rdata",  fetch_rdata,       32'h0);
    check("rst_ready",  32'(load_ready),   32'd0);
    check("rst_words",  32'(load_words),   32'd0);
    check("rst_wr_en",  32'(mem_wr_en),    32'd0);
    tick();
    rst_n = 1'b1; fetch_req = 1'b0;
    tick();

    // Three back-to-back fetches at 0x0004
    $display("FETCH addr=0004 x3");
    fetch_req = 1'b1; fetch_addr = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fetch_gnt", 32'(fetch_gnt), 32'd1);
      check("fetch_addr_out", 32'(mem_addr), 32'h0004);
      if (i > 0) begin
        check("fetch_rvalid", 32'(fetch_rvalid), 32'd1);
        check("fetch_rdata", fetch_rdata, 32'hA5000004);
      end
      tick();
    end
    fetch_req = 1'b0;
    @(negedge clk);
    check("fetch_gnt_off", 32'(fetch_gnt), 32'd0);
    check("fetch_rvalid_last", 32'(fetch_rvalid), 32'd1);
    check("fetch_rdata_last", fetch_rdata, 32'hA5000004);
    tick();
    @(negedge clk);
    check("fetch_rvalid_end", 32'(fetch_rvalid), 32'd0);
    tick();

    // Two full words
    $display("LOAD base=0010 bytes=8");
    wb = wr_cnt; db = done_cnt;
    start_load(16'h0010);
    send(1, 8'h13, 0); send(1, 8'h00, 0); send(1, 8'h00, 0); send(1, 8'h00, 0);
    send(1, 8'h93, 0); send(1, 8'h00, 0); send(1, 8'h10, 0); send(1, 8'h00, 0);
    send(0, 8'h00, 1);
    wait_done();
    tick();
    check("l1_wr_cnt", 32'(wr_cnt - wb), 32'd2);
    check("l1_addr0", 32'(wr_addr[wb]), 32'h0010);
    check("l1_data0", wr_data[wb], 32'h00000013);
    check("l1_addr1", 32'(wr_addr[wb + 1]), 32'h0011);
    check("l1_data1", wr_data[wb + 1], 32'h00100093);
    check("l1_done", 32'(done_cnt - db), 32'd1);
    check("l1_words", 32'(load_words), 32'd2);

    // Partial trailing word with fetch_req held high throughout
    $display("LOAD base=0020 bytes=6 fetch_req held");
    wb = wr_cnt; db = done_cnt;
    fetch_req = 1'b1; fetch_addr = 16'h0004;
    start_load(16'h0020);
    send(1, 8'hAA, 0); send(1, 8'hBB, 0); send(1, 8'hCC, 0); send(1, 8'hDD, 0);
    send(1, 8'h11, 0); send(1, 8'h22, 0);
    send(0, 8'h00, 1);
    wait_done();
    @(negedge clk);
    check("gnt_resume", 32'(fetch_gnt), 32'd1);
    tick();
    fetch_req = 1'b0;
    tick();
    check("l2_wr_cnt", 32'(wr_cnt - wb), 32'd2);
    check("l2_addr0", 32'(wr_addr[wb]), 32'h0020);
    check("l2_data0", wr_data[wb], 32'hDDCCBBAA);
    check("l2_addr1", 32'(wr_addr[wb + 1]), 32'h0021);
    check("l2_data1", wr_data[wb + 1], 32'h00002211);
    check("l2_done", 32'(done_cnt - db), 32'd1);
    check("l2_words", 32'(load_words), 32'd2);
    check("l2_no_gnt_in_load", 32'(bad_gnt), 32'd0);

    // Last byte arrives together with load_end
    $display("LOAD base=0028 bytes=3 end-with-byte");
    wb = wr_cnt; db = done_cnt;
    start_load(16'h0028);
    send(1, 8'h01, 0); send(1, 8'h02, 0); send(1, 8'h03, 1);
    wait_done();
    tick();
    check("l3_wr_cnt", 32'(wr_cnt - wb), 32'd1);
    check("l3_addr0", 32'(wr_addr[wb]), 32'h0028);
    check("l3_data0", wr_data[wb], 32'h00030201);
    check("l3_done", 32'(done_cnt - db), 32'd1);
    check("l3_words", 32'(load_words), 32'd1);

    // Reset in the middle of a word
    $display("LOAD base=0030 bytes=2 then reset");
    wb = wr_cnt; db = done_cnt;
    start_load(16'h0030);
    send(1, 8'h55, 0); send(1, 8'h66, 0);
    fetch_req = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_gnt", 32'(fetch_gnt), 32'd0);
    check("mrst_ready", 32'(load_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_run_gnt", 32'(fetch_gnt), 32'd1);
    check("mrst_run_ready", 32'(load_ready), 32'd0);
    check("mrst_words", 32'(load_words), 32'd0);
    tick();
    fetch_req = 1'b0;
    repeat (4) tick();
    check("mrst_no_write", 32'(wr_cnt - wb), 32'd0);
    check("mrst_no_done", 32'(done_cnt - db), 32'd0);

    // Fetch at 0x0400: out of range only when bounds checking with IMEM_SIZE=1
    $display("FETCH addr=0400");
    fetch_req = 1'b1; fetch_addr = 16'h0400;
    @(negedge clk);
    check("hi_gnt", 32'(fetch_gnt), 32'd1);
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    check("hi_rvalid", 32'(fetch_rvalid), 32'd1);
`ifdef IMEM_BOUNDS_CHK_EN
    check("hi_err", 32'(fetch_err), 32'd1);
    check("hi_rdata", fetch_rdata, 32'h00000013);
`else
    check("hi_rdata", fetch_rdata, 32'hA5000400);
`endif
    tick();
    $display("FETCH addr=03FF");
    fetch_req = 1'b1; fetch_addr = 16'h03FF;
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    check("lo_rvalid", 32'(fetch_rvalid), 32'd1);
`ifdef IMEM_BOUNDS_CHK_EN
    check("lo_err", 32'(fetch_err), 32'd0);
`endif
    check("lo_rdata", fetch_rdata, 32'hA50003FF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
